// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the distributed-RAM FIFO controller.
package dpram_fifo_ctrl_pkg;

    // Pointer width: one extra wrap bit above the RAM address width, so that
    // full and empty can be told apart when the address bits are equal.
    function automatic int fifo_ptr_w(input int awidth);
        return awidth + 1;
    endfunction

    // Default almost-full level: two words below a completely full FIFO.
    function automatic int afull_thresh_default(input int awidth);
        return (1 << awidth) - 2;
    endfunction

endpackage

// File: rtl/dpram_fifo_ctrl_ptr.sv
// FIFO pointer: wrap-bit counter with an increment enable and a synchronous
// load, which the read side uses to snap onto the write pointer on flush.
module dpram_fifo_ctrl_ptr #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] ptr
);

    // Load wins over increment; the counter wraps naturally modulo 2**W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller sequencing an external dual-port distributed RAM
// (port 0 write, port 1 asynchronous read) with first-word-fallthrough output.
module dpram_fifo_ctrl
    import dpram_fifo_ctrl_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int AWIDTH       = 4,
    parameter int AFULL_THRESH = afull_thresh_default(AWIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH:0]   count,
    output logic              almost_full,
    output logic [AWIDTH-1:0] ram_addr0,
    output logic [DWIDTH-1:0] ram_d0,
    output logic              ram_we0,
    output logic [AWIDTH-1:0] ram_addr1,
    output logic [DWIDTH-1:0] ram_d1,
    output logic              ram_we1,
    input  logic [DWIDTH-1:0] ram_q1
);

    localparam int PW = fifo_ptr_w(AWIDTH);
    localparam logic [PW-1:0] AFULL_CNT = PW'(AFULL_THRESH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_q;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    // Status and handshake decode; ready/valid depend only on registered pointers.
    always_comb begin
        empty     = (wr_ptr == rd_ptr);
        full      = (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]) &&
                    (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]);
        in_ready  = !full;
        out_valid = !empty;
        // rst_n gates the write so a word offered while reset is held never
        // reaches the RAM, even though in_ready reads 1 during reset.
        push      = in_valid && in_ready && !flush && rst_n;
        pop       = out_valid && out_ready && !flush;
    end

    // RAM port wiring: port 0 writes at the tail, port 1 reads the head.
    always_comb begin
        ram_we0   = push;
        ram_addr0 = wr_ptr[AWIDTH-1:0];
        ram_d0    = in_data;
        ram_addr1 = rd_ptr[AWIDTH-1:0];
        ram_d1    = '0;
        ram_we1   = 1'b0;
        out_data  = ram_q1;
    end

    dpram_fifo_ctrl_ptr #(.W(PW)) u_wr_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (push),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (wr_ptr)
    );

    // Flush drops every stored word by moving the read side up to the write side.
    dpram_fifo_ctrl_ptr #(.W(PW)) u_rd_ptr (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pop),
        .load     (flush),
        .load_val (wr_ptr),
        .ptr      (rd_ptr)
    );

    // Occupancy register: cleared by flush, otherwise tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (flush) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + PW'(1);
                2'b01:   count_q <= count_q - PW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Occupancy outputs taken straight from the registered count.
    always_comb begin
        count       = count_q;
        almost_full = (count_q >= AFULL_CNT);
    end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sequences an external dual-port distributed RAM with asynchronous read.
- Port 0 of the RAM is the write port; port 1 is the read port.
- Presents valid/ready streaming interfaces on both sides with first-word-fallthrough output.
- Sits between a producer and a consumer wherever a small, LUT-RAM-backed elastic buffer is needed.

Parameters:
- DWIDTH, 8, data width; matches the RAM data width.
- AWIDTH, 4, RAM address width; FIFO depth = 2**AWIDTH.
- AFULL_THRESH, 2**AWIDTH-2, occupancy at or above which almost_full asserts; legal range 1..2**AWIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of the FIFO state.
- in_data  in  DWIDTH  write data from the producer.
- in_valid  in  1  producer offers in_data.
- in_ready  out  1  FIFO can accept a word.
- out_data  out  DWIDTH  head-of-FIFO data.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts out_data.
- count  out  AWIDTH+1  current occupancy, 0..2**AWIDTH.
- almost_full  out  1  count >= AFULL_THRESH.
- ram_addr0  out  AWIDTH  RAM write address.
- ram_d0  out  DWIDTH  RAM write data.
- ram_we0  out  1  RAM write enable.
- ram_addr1  out  AWIDTH  RAM read address.
- ram_d1  out  DWIDTH  tied to 0.
- ram_we1  out  1  tied to 0.
- ram_q1  in  DWIDTH  RAM asynchronous read data for ram_addr1.

Behaviour:
- State: wr_ptr and rd_ptr, each AWIDTH+1 bits (the extra MSB is the wrap bit), plus a registered count.
- Reset (rst_n low, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0.
  - Resulting outputs: in_ready=1, out_valid=0, almost_full=0 (given AFULL_THRESH>=1), ram_we0=0.
  - RAM contents are not cleared.
- empty = (wr_ptr == rd_ptr).
- full = (low AWIDTH bits equal) and (MSBs differ).
- in_ready = !full.
- out_valid = !empty.
- Both in_ready and out_valid are purely functions of registered state, with no combinational path from in_valid or out_ready.
- push = in_valid & in_ready & !flush.
- pop = out_valid & out_ready & !flush.
- ram_we0 = push.
- ram_addr0 = wr_ptr[AWIDTH-1:0].
- ram_d0 = in_data.
- ram_addr1 = rd_ptr[AWIDTH-1:0].
- out_data = ram_q1 (combinational). Read latency is zero: the head word is visible the same cycle out_valid is high.
- Write-to-read latency is 1 cycle. A word pushed at edge N is visible on out_data with out_valid=1 after edge N. There is no same-cycle bypass when empty.
- On a clock edge:
  - push: wr_ptr += 1, wrapping modulo 2**(AWIDTH+1).
  - pop: rd_ptr += 1.
  - count += push - pop. Simultaneous push and pop leaves count unchanged.
- Full: push is blocked by in_ready=0 even if a pop occurs in the same cycle.
- Empty: pop is impossible because out_valid=0.
- flush=1:
  - Next edge sets rd_ptr = wr_ptr and count = 0.
  - flush overrides push and pop; ram_we0=0 during flush.
- almost_full = (count >= AFULL_THRESH). Combinational from the registered count.
- Reset asserted mid-transfer clears state immediately. A write in flight that cycle is discarded.
- out_data is don't-care while out_valid=0. The bench must not check it then.

Decomposition:
- Shared package:
  - FIFO pointer-width helper constant (AWIDTH+1).
  - Default AFULL_THRESH expression.
- No sub-module in this block. The RAM is instantiated beside it by the parent, and wired port0=write, port1=read.
- One natural shared sub-module: fifo_ptr (counter with wrap bit and increment enable), reusable for both pointers.

Test Plan (AWIDTH=2, DWIDTH=8, AFULL_THRESH=3, with behavioural RAM attached):
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, out_valid=0, count=0, ram_we0=0. After release, out_valid stays 0 until the first push.
- Fill: push 0x11, 0x22, 0x33, 0x44 back-to-back with out_ready=0 ->
  - count 1,2,3,4.
  - almost_full rises after the 3rd push.
  - in_ready=0 after the 4th push; a 5th offer (0x55) is not accepted.
- Drain order: from full, set out_ready=1 -> out_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Then out_valid=0 and count=0.
- Simultaneous push and pop:
  - With count=2, push and pop in the same cycle for 10 cycles -> count stays 2.
  - Output sequence equals input order across pointer wrap (at least 2 wraps).
- Full plus pop: at count=4, assert in_valid=1 and out_ready=1 -> push refused that cycle, count=3. Next cycle the push is accepted and count=4.
- Flush and async reset: at count=3, pulse flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, no RAM write. Asserting rst_n=0 mid-burst clears count without waiting for a clock edge.
